// File: rtl/fix2flt_seq.sv
// fix2flt_seq: sequential converter from signed 8.8 fixed point to IEEE-754 half.
// Normalises one bit per clock. The mantissa is truncated, not rounded.
//
// Ports:
//   Clk      - clock, rising-edge active
//   Reset    - asynchronous active-low reset
//   Start    - conversion request, accepted only in idle/done
//   fix_in   - signed two's-complement 8.8 operand, captured when Start is accepted
//   flt_out  - half-precision result {sign, exp[4:0], mant[9:0]}
//   Done     - result-valid level, held until the next accepted Start
//   Busy     - high while a conversion is in progress
module fix2flt_seq #(
  parameter int unsigned BIAS = 15
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [15:0] fix_in,
  output logic [15:0] flt_out,
  output logic        Done,
  output logic        Busy
);

  // An 8.8 value with its leading one at bit 15 is 2^7 times the hidden-one form.
  localparam logic [4:0] ExpInit = 5'(BIAS + 7);

  typedef enum logic [2:0] {StIdle, StLoad, StNorm, StPack, StDone} state_e;

  state_e      state_q, state_d;
  logic [15:0] fix_q, fix_d;
  logic        ld_q, ld_d;    // LOAD spans two edges: register operand, then dispatch
  logic        sign_q, sign_d;
  logic [15:0] mag_q, mag_d;
  logic [4:0]  exp_q, exp_d;
  logic [15:0] flt_q, flt_d;
  logic [15:0] mag_abs;

  // 0x8000 negates to itself, which is the correct 16-bit unsigned magnitude.
  assign mag_abs = fix_q[15] ? (~fix_q + 16'd1) : fix_q;

  always_comb begin
    state_d = state_q;
    fix_d   = fix_q;
    ld_d    = ld_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    exp_d   = exp_q;
    flt_d   = flt_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (Start) begin
          fix_d   = fix_in;
          ld_d    = 1'b0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (!ld_q) begin
          sign_d = fix_q[15];
          mag_d  = mag_abs;
          exp_d  = ExpInit;
          ld_d   = 1'b1;
        end else if (mag_q == 16'd0) begin
          // Zero bypasses normalisation; sign cleared so -0 never appears.
          sign_d  = 1'b0;
          flt_d   = 16'h0000;
          state_d = StDone;
        end else if (mag_q[15]) begin
          state_d = StPack;
        end else begin
          state_d = StNorm;
        end
      end
      StNorm: begin
        if (!mag_q[15]) begin
          mag_d = {mag_q[14:0], 1'b0};
          exp_d = exp_q - 5'd1;
          // Leave as soon as the shift lands the leading one at bit 15.
          if (mag_q[14]) state_d = StPack;
        end else begin
          state_d = StPack;
        end
      end
      StPack: begin
        flt_d   = {sign_q, exp_q, mag_q[14:5]};
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= StIdle;
      fix_q   <= 16'h0000;
      ld_q    <= 1'b0;
      sign_q  <= 1'b0;
      mag_q   <= 16'h0000;
      exp_q   <= 5'd0;
      flt_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      fix_q   <= fix_d;
      ld_q    <= ld_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      exp_q   <= exp_d;
      flt_q   <= flt_d;
    end
  end

  assign flt_out = flt_q;
  assign Done    = (state_q == StDone);
  assign Busy    = (state_q == StLoad) || (state_q == StNorm) || (state_q == StPack);

endmodule

// File: doc/fix2flt_seq.md
FIX2FLT_SEQ -- requirements
Module: fix2flt_seq

Interface
REQ-001 SHALL have parameter BIAS, default 15, the half-precision exponent bias.
REQ-002 SHALL have port Clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset, input, 1 bit; reset is asynchronous and active-low.
REQ-004 SHALL have port Start, input, 1 bit, conversion request, sampled on Clk rising edges.
REQ-005 SHALL have port fix_in, input, 16 bits, signed two's-complement 8.8 fixed-point operand.
REQ-006 SHALL have port flt_out, output, 16 bits, IEEE-754 half result laid out as {sign, exp[4:0], mant[9:0]}.
REQ-007 SHALL have port Done, output, 1 bit, result-valid level.
REQ-008 SHALL have port Busy, output, 1 bit, high while a conversion is in progress.

Function
REQ-009 SHALL implement states IDLE, LOAD, NORM, PACK and DONE, all registered.
REQ-010 SHALL, in IDLE or DONE with Start=1 at an edge (edge 0), capture fix_in, clear Done and enter LOAD.
REQ-011 SHALL ignore Start while in LOAD, NORM or PACK; no re-capture and no abort.
REQ-012 SHALL, at the LOAD edge (edge 1), register sign=fix_in[15], mag=|fix_in| as 16-bit unsigned (0x8000 gives mag 0x8000), and exp=BIAS+7 (22).
REQ-013 SHALL go from LOAD directly to DONE when mag==0, with flt_out=0x0000 and sign forced to 0; -0 is never produced.
REQ-014 SHALL, otherwise, enter NORM from LOAD.
REQ-015 SHALL, in NORM with mag[15]==0, shift mag left by 1 and decrement exp by 1 per cycle, one bit per clock.
REQ-016 SHALL leave NORM for PACK once mag[15]==1.
REQ-017 Let k = 15 - p, where p is the index of the leading one of the captured mag.
REQ-018 SHALL take exactly k NORM shift cycles; PACK is entered at edge 2+k.
REQ-019 SHALL, at the PACK edge (edge 3+k), register flt_out={sign, exp[4:0], mag[14:5]}, set Done=1 and enter DONE.
REQ-020 SHALL truncate the mantissa, discarding mag[4:0]; no rounding is performed.
REQ-021 SHALL keep the exponent within 7..22 for every input; no overflow, denormal, Inf or NaN output exists.
REQ-022 SHALL hold Done=1 and flt_out stable in DONE until the next accepted Start.
REQ-023 SHALL, when Start is accepted in DONE, drop Done at that edge and leave flt_out at its old value until the new result is written.
REQ-024 SHALL assert Busy exactly in LOAD, NORM and PACK; Busy and Done are never both 1.
REQ-025 SHALL bound latency from the Start sample edge to Done=1 as follows:
- zero input: 2 cycles;
- non-zero input: 3+k cycles, i.e. 3 to 18 cycles.
REQ-026 SHALL ignore fix_in changes after capture for the rest of that conversion.

Reset
REQ-027 SHALL, while Reset=0, asynchronously force state=IDLE, flt_out=0x0000, Done=0, Busy=0 and internal mag/exp/sign to 0.
REQ-028 SHALL abort any conversion in progress on reset assertion; no Done for the aborted operand.
REQ-029 SHALL, after Reset deasserts, accept Start at the first rising edge with Reset=1.

Verification
REQ-030 Scenario: fix_in=0x0100 (1.0), Start pulse -> flt_out=0x3C00, Done rises at edge 10 (k=7).
REQ-031 Scenarios, positive values:
- 0x0180 (1.5) -> 0x3E00;
- 0x0001 (2^-8) -> 0x1C00 at edge 18;
- 0x7FFF -> 0x57FF (truncation check).
REQ-032 Scenarios, negative values:
- 0xFEC0 (-1.25) -> 0xBD00;
- 0x8000 (-128.0) -> 0xD800 at edge 3 (k=0).
REQ-033 Scenario: fix_in=0x0000 -> flt_out=0x0000, Done at edge 2, Busy high only during LOAD.
REQ-034 Scenario: Start re-pulsed during NORM with a different fix_in -> ignored; the first result completes unchanged.
REQ-035 Scenario: back-to-back conversions -> Start in DONE with 0x0200 -> Done drops at that edge, then 0x4000 at edge 9.
REQ-036 Scenario: Reset driven low mid-NORM -> outputs 0 immediately; the next Start with 0x0100 -> 0x3C00.
